tone_bank: RTL and testbench

Parametrised multi-channel tone/noise generator for the keyboard front end. It provides NUM_CH independent channels, each with a run-time programmable half-period divider and a mode of off, square or LFSR noise. A key gate per channel is applied only at waveform phase boundaries, so gating does not produce clicks. Outputs drive GPIO speaker pins directly; a live-voice count feeds the status display.

---
 rtl/tone_pkg.sv | 29 ++
 rtl/tone_channel.sv | 108 ++++++++++
 rtl/tone_bank.sv | 72 +++++++
 tb/tb_tone_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone bank: mode encodings, LFSR polynomial and seeds,
// and the mode decode that folds the reserved encoding onto off.
package tone_pkg;

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_SQUARE = 2'd1;
   localparam logic [1:0] MODE_NOISE  = 2'd2;

   localparam int LFSR_W = 8;
   // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps b7,b5,b4,b3
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

   function automatic logic [LFSR_W-1:0] seed(input int unsigned i);
      seed = LFSR_W'(i + 32'd1);
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      lfsr_next = {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [1:0] decode_mode(input logic [1:0] m);
      case (m)
         MODE_SQUARE: decode_mode = MODE_SQUARE;
         MODE_NOISE:  decode_mode = MODE_NOISE;
         default:     decode_mode = MODE_OFF;
      endcase
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone/noise voice: double-buffered config, half-period counter, phase, LFSR,
// key synchroniser and a gate that only changes at phase boundaries or while idle.
module tone_channel
   import tone_pkg::*;
#(
   parameter int DIV_W = 24,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] half,
   input  logic             key,
   output logic             tone,
   output logic             voice
);

   logic [1:0]        act_mode_r;
   logic [1:0]        pend_mode_r;
   logic [DIV_W-1:0]  act_half_r;
   logic [DIV_W-1:0]  pend_half_r;
   logic [DIV_W-1:0]  cnt_r;
   logic              phase_r;
   logic              gate_r;
   logic [1:0]        key_sync_r;
   logic [LFSR_W-1:0] lfsr_r;
   logic              tone_r;

   logic [1:0]        wr_mode_s;
   logic              idle_s;
   logic              wrap_s;
   logic              wave_s;

   always_comb begin
      wr_mode_s = decode_mode(mode);
      idle_s    = (act_half_r == '0) || (act_mode_r == MODE_OFF);
      wrap_s    = !idle_s && (cnt_r == act_half_r - DIV_W'(1));
   end

   // A wrap promotes the pending cfg as it stood before this cycle's write
   always_ff @(posedge clk) begin
      if (!reset) begin
         act_mode_r  <= MODE_OFF;
         act_half_r  <= '0;
         pend_mode_r <= MODE_OFF;
         pend_half_r <= '0;
         cnt_r       <= '0;
         phase_r     <= 1'b0;
      end else begin
         if (wr) begin
            pend_mode_r <= wr_mode_s;
            pend_half_r <= half;
         end
         if (idle_s) begin
            if (wr) begin
               act_mode_r <= wr_mode_s;
               act_half_r <= half;
               cnt_r      <= '0;
               phase_r    <= 1'b0;
            end
         end else if (wrap_s) begin
            act_mode_r <= pend_mode_r;
            act_half_r <= pend_half_r;
            cnt_r      <= '0;
            phase_r    <= ~phase_r;
         end else begin
            cnt_r <= cnt_r + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         key_sync_r <= 2'b00;
         gate_r     <= 1'b0;
         lfsr_r     <= seed(IDX);
      end else begin
         key_sync_r <= {key_sync_r[0], key};
         if (idle_s || (wrap_s && phase_r)) begin
            gate_r <= key_sync_r[1];
         end
         if (wrap_s && !phase_r && (act_mode_r == MODE_NOISE)) begin
            lfsr_r <= lfsr_next(lfsr_r);
         end
      end
   end

   always_comb begin
      case (act_mode_r)
         MODE_SQUARE: wave_s = phase_r;
         MODE_NOISE:  wave_s = lfsr_r[0];
         default:     wave_s = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tone_r <= 1'b0;
      end else begin
         tone_r <= gate_r & wave_s;
      end
   end

   assign tone  = tone_r;
   assign voice = gate_r & ((act_mode_r == MODE_SQUARE) || (act_mode_r == MODE_NOISE));

endmodule

// File: rtl/tone_bank.sv
// Multi-channel tone/noise generator: decodes config writes to channels and
// reports a registered count of live voices.
module tone_bank
   import tone_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int DIV_W  = 24,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int ACT_W  = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [1:0]        wr_mode,
   input  logic [DIV_W-1:0]  wr_half,
   input  logic [NUM_CH-1:0] key,
   output logic [NUM_CH-1:0] tone_out,
   output logic [ACT_W-1:0]  active
);

   logic [NUM_CH-1:0] wr_sel_s;
   logic [NUM_CH-1:0] voice_s;
   logic [ACT_W-1:0]  count_s;
   logic [ACT_W-1:0]  active_r;

   // Out-of-range wr_ch matches no channel and is dropped
   always_comb begin
      wr_sel_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_en && (wr_ch == CH_W'(i))) begin
            wr_sel_s[i] = 1'b1;
         end else begin
            wr_sel_s[i] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tone_channel #(
         .DIV_W (DIV_W),
         .IDX   (g)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .wr    (wr_sel_s[g]),
         .mode  (wr_mode),
         .half  (wr_half),
         .key   (key[g]),
         .tone  (tone_out[g]),
         .voice (voice_s[g])
      );
   end

   always_comb begin
      count_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         count_s = count_s + ACT_W'(voice_s[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         active_r <= '0;
      end else begin
         active_r <= count_s;
      end
   end

   assign active = active_r;

endmodule

// File: tb/tb_tone_bank.sv
// Self-checking bench for tone_bank: a cycle-level reference model built from the
// channel rules (countdown to wrap, integer modes) plus directed period checks.
module tb_tone_bank;

   localparam int NCH = 6;
   localparam int DW  = 24;
   localparam int CHW = 3;
   localparam int AW  = $clog2(NCH + 1);

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           wr_en = 1'b0;
   logic [CHW-1:0] wr_ch = '0;
   logic [1:0]     wr_mode = 2'd0;
   logic [DW-1:0]  wr_half = '0;
   logic [NCH-1:0] key = '0;
   logic [NCH-1:0] tone_out;
   logic [AW-1:0]  active;

   tone_bank #(.NUM_CH(NCH), .DIV_W(DW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
      .wr_half(wr_half), .key(key), .tone_out(tone_out), .active(active)
   );

   always #5 clk = ~clk;

   typedef struct {
      int amode, ahalf, pmode, phalf, left;
      bit phase, gate, k0, k1;
      logic [7:0] lfsr;
   } ch_t;

   ch_t            m [NCH];
   logic [NCH-1:0] exp_tone;
   int             exp_active;
   int             checks = 0;
   int             errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] poly_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m[c] = '{amode: 0, ahalf: 0, pmode: 0, phalf: 0, left: 0,
                  phase: 1'b0, gate: 1'b0, k0: 1'b0, k1: 1'b0, lfsr: 8'(c + 1)};
      end
      exp_tone   = '0;
      exp_active = 0;
   endfunction

   // Advance the reference by one clock edge using the inputs present at that edge
   function automatic void model_edge();
      int  act;
      int  wm;
      bit  running;
      bit  w;
      ch_t c;
      ch_t n;
      act = 0;
      wm  = (wr_mode == 2'd3) ? 0 : int'(wr_mode);
      for (int ch = 0; ch < NCH; ch++) begin
         c = m[ch];
         n = c;
         exp_tone[ch] = c.gate && ((c.amode == 1) ? c.phase : (c.amode == 2) ? c.lfsr[0] : 1'b0);
         if (c.gate && (c.amode == 1 || c.amode == 2)) act++;
         running = (c.ahalf != 0) && (c.amode != 0);
         w = wr_en && (int'(wr_ch) == ch);
         n.k0 = key[ch];
         n.k1 = c.k0;
         if (w) begin
            n.pmode = wm;
            n.phalf = int'(wr_half);
         end
         if (!running) begin
            n.gate = c.k1;
            if (w) begin
               n.amode = wm;
               n.ahalf = int'(wr_half);
               n.left  = int'(wr_half);
               n.phase = 1'b0;
            end
         end else if (c.left == 1) begin
            n.amode = c.pmode;
            n.ahalf = c.phalf;
            n.left  = c.phalf;
            n.phase = !c.phase;
            if (!c.phase && c.amode == 2) n.lfsr = poly_step(c.lfsr);
            if (c.phase) n.gate = c.k1;
         end else begin
            n.left = c.left - 1;
         end
         m[ch] = n;
      end
      exp_active = act;
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge();
      #1;
      check_val("tone_out", 32'(tone_out), 32'(exp_tone));
      check_val("active", 32'(active), 32'(exp_active));
   endtask

   task automatic do_write(input int ch, input int mode, input int half);
      wr_en   = 1'b1;
      wr_ch   = CHW'(ch);
      wr_mode = 2'(mode);
      wr_half = DW'(half);
      cycle();
      wr_en   = 1'b0;
   endtask

   // Cycles until tone_out[ch] next changes (bounded)
   task automatic next_len(input int ch, output int len);
      logic v;
      v   = tone_out[ch];
      len = 0;
      while (tone_out[ch] == v && len < 300) begin
         cycle();
         len++;
      end
   endtask

   initial begin
      int len;
      int n;
      model_reset();
      reset = 1'b0;
      repeat (4) cycle();
      reset = 1'b1;
      cycle();
      check_val("reset_tone", 32'(tone_out), 32'd0);
      check_val("reset_active", 32'(active), 32'd0);

      // square on ch0, half 5
      key[0] = 1'b1;
      key[2] = 1'b1;
      repeat (3) cycle();
      do_write(0, 1, 5);
      repeat (12) cycle();
      next_len(0, len);
      next_len(0, len);
      check_val("ch0_half5_a", 32'(len), 32'd5);
      next_len(0, len);
      check_val("ch0_half5_b", 32'(len), 32'd5);
      check_val("ch0_active", 32'(active), 32'd1);

      // noise on ch1, half 2
      key[1] = 1'b1;
      repeat (3) cycle();
      do_write(1, 2, 2);
      repeat (20) cycle();
      next_len(1, len);
      next_len(1, len);
      check_val("ch1_noise_run_mod4", 32'(len % 4), 32'd0);
      repeat (300) cycle();

      // key drop mid high half-period on ch0, half 8
      do_write(0, 1, 8);
      repeat (40) cycle();
      if (tone_out[0]) next_len(0, len);
      next_len(0, len);
      key[0] = 1'b0;
      n = 0;
      while (tone_out[0] && n < 100) begin
         n++;
         cycle();
      end
      check_val("ch0_keydrop_high", 32'(n), 32'd8);
      repeat (40) cycle();
      check_val("ch0_gated_off", 32'(tone_out[0]), 32'd0);

      // ch2 rewrite on the exact wrap edge
      do_write(2, 1, 4);
      repeat (10) cycle();
      n = 0;
      while (!(m[2].ahalf != 0 && m[2].amode != 0 && m[2].left == 1) && n < 50) begin
         cycle();
         n++;
      end
      check_val("ch2_wrap_found", 32'(n < 50), 32'd1);
      do_write(2, 1, 6);
      cycle();
      next_len(2, len);
      check_val("ch2_old_half", 32'(len), 32'd4);
      next_len(2, len);
      check_val("ch2_new_half", 32'(len), 32'd6);

      // out-of-range channel writes
      do_write(NCH, 1, 3);
      do_write(7, 2, 1);
      repeat (30) cycle();
      check_val("ch3_untouched", 32'(tone_out[3]), 32'd0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         wr_en   = ($urandom % 4) == 0;
         wr_ch   = CHW'($urandom % 8);
         wr_mode = 2'($urandom % 4);
         wr_half = (($urandom % 8) == 0) ? '0 : DW'($urandom_range(1, 12));
         if (($urandom % 12) == 0) begin
            n = $urandom % NCH;
            key[n] = ~key[n];
         end
         reset = ($urandom % 500) != 0;
         cycle();
      end
      wr_en = 1'b0;
      reset = 1'b1;

      // everything running, then reset mid-tone
      key = '1;
      for (int c = 0; c < NCH; c++) do_write(c, (c % 2) + 1, c + 2);
      repeat (30) cycle();
      reset = 1'b0;
      cycle();
      check_val("midtone_reset_tone", 32'(tone_out), 32'd0);
      check_val("midtone_reset_active", 32'(active), 32'd0);
      reset = 1'b1;
      repeat (5) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
